// File: rtl/round_pack_float.sv
// round_pack_float: round-and-pack stage for the soft-float datapath.
//
// Takes a sign, a two's-complement biased exponent and an extended significand
// (leading one at bit SIG_W-2, low RB bits are round bits). It rounds with one
// of four modes and packs a {sign, exponent, fraction} IEEE-754 word. The
// overflow, underflow and inexact flags are ORed into the incoming sticky flags.
// The exponent is one below the packed exponent field, because the leading
// significand bit is added into the exponent field by the pack addition.
//
// Ports
//   ap_clk, ap_rst          clock, asynchronous active-high reset
//   ap_start                request, sampled in IDLE
//   ap_done, ap_ready       high for the single DONE cycle
//   ap_idle                 IDLE and no pending request
//   zSign, zExp, zSig       operand: sign, biased exponent, significand
//   rmode                   0 nearest-even, 1 to-zero, 2 down, 3 up
//   float_exception_flag_i  incoming sticky flags
//   float_exception_flag_o  flags out (new flags ORed in during DONE)
//   float_exception_flag_o_ap_vld  strobe in DONE
//   ap_return               packed result, zero-extended to SIG_W bits
module round_pack_float #(
  parameter int unsigned EXP_W  = 11,
  parameter int unsigned FRAC_W = 52
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                ap_start,
  output logic                ap_done,
  output logic                ap_ready,
  output logic                ap_idle,
  input  logic                zSign,
  input  logic [EXP_W:0]      zExp,
  input  logic [FRAC_W+11:0]  zSig,
  input  logic [1:0]          rmode,
  input  logic [31:0]         float_exception_flag_i,
  output logic [31:0]         float_exception_flag_o,
  output logic                float_exception_flag_o_ap_vld,
  output logic [FRAC_W+11:0]  ap_return
);

  localparam int unsigned SIG_W = FRAC_W + 12;
  localparam int unsigned RB    = 10;
  localparam int unsigned PK_W  = EXP_W + FRAC_W + 1;
  localparam int unsigned SR_W  = SIG_W - RB;

  // 2^EXP_W - 3: top EXP_W-2 bits set, then 01.
  localparam logic [EXP_W:0]   MaxE  = {1'b0, {(EXP_W-2){1'b1}}, 2'b01};
  localparam logic [SIG_W-1:0] RMask = {{(SIG_W-RB){1'b0}}, {RB{1'b1}}};
  localparam logic [SIG_W-1:0] RHalf = {{(SIG_W-RB){1'b0}}, 1'b1, {(RB-1){1'b0}}};

  // Flag bit positions in the 4-bit new-flag register.
  localparam int unsigned FlInexact = 0;
  localparam int unsigned FlUnder   = 2;

  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StAlign = 4'b0010,
    StRound = 4'b0100,
    StDone  = 4'b1000
  } state_e;

  state_e             state_q, state_d;
  logic               sign_q, sign_d;
  logic [EXP_W:0]     exp_q, exp_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [1:0]         rmode_q, rmode_d;
  logic [31:0]        flag_q, flag_d;
  logic [3:0]         nflag_q, nflag_d;
  logic [SIG_W-1:0]   ret_q, ret_d;

  function automatic logic [SIG_W-1:0] round_inc(input logic sign, input logic [1:0] rm);
    logic [SIG_W-1:0] inc;
    case (rm)
      2'd0:    inc = RHalf;
      2'd1:    inc = '0;
      2'd2:    inc = sign ? RMask : '0;
      default: inc = sign ? '0 : RMask;
    endcase
    return inc;
  endfunction

  // Overflow detection and saturated result, evaluated on the live operands in IDLE.
  logic [SIG_W-1:0] inc_in;
  logic             sum_in_msb;
  logic [SIG_W-2:0] unused_sum_in;
  logic             ovf_in;
  logic             inc_zero_in;
  logic [PK_W-1:0]  ovf_word;

  always_comb begin
    inc_in                      = round_inc(zSign, rmode);
    {sum_in_msb, unused_sum_in} = zSig + inc_in;
    ovf_in      = ($signed(zExp) > $signed(MaxE)) || ((zExp == MaxE) && sum_in_msb);
    inc_zero_in = (inc_in == '0);
    // Infinity, or the largest finite value when rounding never moves away from zero.
    ovf_word    = {zSign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                - {{(PK_W-1){1'b0}}, inc_zero_in};
  end

  // Jamming right shift for subnormals: bits shifted out stick in the LSB.
  logic [EXP_W:0]   shamt;
  logic [31:0]      shamt_wide;
  logic [SIG_W-1:0] lost_mask;
  logic [SIG_W-1:0] jam_sig;

  always_comb begin
    shamt      = '0 - exp_q;
    shamt_wide = 32'(shamt);
    lost_mask  = '0;
    jam_sig    = '0;
    if (shamt_wide >= SIG_W) begin
      jam_sig[0] = |sig_q;
    end else begin
      lost_mask  = ~({SIG_W{1'b1}} << shamt);
      jam_sig    = sig_q >> shamt;
      jam_sig[0] = jam_sig[0] | (|(sig_q & lost_mask));
    end
  end

  // Rounding and packing from the registered operand.
  logic [SIG_W-1:0] inc_q;
  logic [RB-1:0]    round_bits;
  logic [SR_W-1:0]  sig_r;
  logic [RB-1:0]    unused_sum_rb;
  logic [EXP_W-1:0] exp_r;
  logic [PK_W-1:0]  pack_word;

  always_comb begin
    inc_q                  = round_inc(sign_q, rmode_q);
    round_bits             = sig_q[RB-1:0];
    {sig_r, unused_sum_rb} = sig_q + inc_q;
    // Exact tie in nearest-even: force the result even.
    if ((rmode_q == 2'd0) && (round_bits == RHalf[RB-1:0])) begin
      sig_r[0] = 1'b0;
    end
    exp_r = (sig_r == '0) ? '0 : exp_q[EXP_W-1:0];
    // Addition, not concatenation: a significand carry must ripple into the exponent.
    pack_word = {sign_q, {(PK_W-1){1'b0}}}
              + {1'b0, exp_r, {FRAC_W{1'b0}}}
              + {{(PK_W-SR_W){1'b0}}, sig_r};
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    sig_d   = sig_q;
    rmode_d = rmode_q;
    flag_d  = flag_q;
    nflag_d = nflag_q;
    ret_d   = ret_q;
    unique case (state_q)
      StIdle: begin
        if (ap_start) begin
          sign_d  = zSign;
          exp_d   = zExp;
          sig_d   = zSig;
          rmode_d = rmode;
          flag_d  = float_exception_flag_i;
          nflag_d = '0;
          if (ovf_in) begin
            ret_d              = '0;
            ret_d[PK_W-1:0]    = ovf_word;
            nflag_d            = 4'b1001;
            state_d            = StDone;
          end else if (zExp[EXP_W]) begin
            state_d = StAlign;
          end else begin
            state_d = StRound;
          end
        end
      end
      StAlign: begin
        sig_d            = jam_sig;
        exp_d            = '0;
        // Tininess is judged before rounding.
        nflag_d[FlUnder] = (jam_sig[RB-1:0] != '0);
        state_d          = StRound;
      end
      StRound: begin
        ret_d              = '0;
        ret_d[PK_W-1:0]    = pack_word;
        nflag_d[FlInexact] = (round_bits != '0);
        state_d            = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      sig_q   <= '0;
      rmode_q <= '0;
      flag_q  <= '0;
      nflag_q <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      sig_q   <= sig_d;
      rmode_q <= rmode_d;
      flag_q  <= flag_d;
      nflag_q <= nflag_d;
      ret_q   <= ret_d;
    end
  end

  // Outputs.
  logic in_done;

  always_comb begin
    in_done                       = (state_q == StDone);
    ap_done                       = in_done;
    ap_ready                      = in_done;
    ap_idle                       = (state_q == StIdle) && !ap_start;
    float_exception_flag_o_ap_vld = in_done;
    float_exception_flag_o        = in_done ? (flag_q | {28'd0, nflag_q})
                                            : float_exception_flag_i;
    ap_return                     = ret_q;
  end

endmodule
